// File: rtl/xo_dac_spi_ctrl.sv
// SPI write sequencer for the XO trim DAC: mode 0, MSB-first, with nCs setup/hold/gap timing.
// Optional shadow of the last completed word behind XO_DAC_SPI_CTRL_SHADOW_EN.
module xo_dac_spi_ctrl #(
  parameter int WIDTH    = 24,
  parameter int CLKDIV   = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int GAP      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             wr_valid,
  output logic             wr_ready,
  output logic             busy,
  output logic             done,
  output logic             ncs_xo,
  output logic             sck,
  output logic             mosi
`ifdef XO_DAC_SPI_CTRL_SHADOW_EN
  ,
  output logic [WIDTH-1:0] last_word
`endif
);

  localparam int CMAX_A = (CLKDIV > CS_SETUP) ? CLKDIV : CS_SETUP;
  localparam int CMAX_B = (CS_HOLD > GAP) ? CS_HOLD : GAP;
  localparam int CMAX   = (CMAX_A > CMAX_B) ? CMAX_A : CMAX_B;
  localparam int CW     = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam int BW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_GAP} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [BW-1:0]    bit_cnt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_sh;

  assign shreg_sh = shreg << 1;

`ifdef XO_DAC_SPI_CTRL_SHADOW_EN
  logic [WIDTH-1:0] word_q;
`endif

  // Outputs are registered together with the state, so they change on the transition edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      wr_ready <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      ncs_xo   <= 1'b1;
      sck      <= 1'b0;
      mosi     <= 1'b0;
`ifdef XO_DAC_SPI_CTRL_SHADOW_EN
      word_q    <= '0;
      last_word <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (wr_valid) begin
            state    <= S_SETUP;
            cnt      <= CW'(CS_SETUP - 1);
            bit_cnt  <= BW'(WIDTH - 1);
            shreg    <= wr_data;
            mosi     <= wr_data[WIDTH-1];
            ncs_xo   <= 1'b0;
            wr_ready <= 1'b0;
            busy     <= 1'b1;
`ifdef XO_DAC_SPI_CTRL_SHADOW_EN
            word_q   <= wr_data;
`endif
          end
        end
        S_SETUP: begin
          if (cnt == '0) begin
            state <= S_SHIFT;
            cnt   <= CW'(CLKDIV - 1);
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_SHIFT: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (!sck) begin
            sck <= 1'b1;
            cnt <= CW'(CLKDIV - 1);
          end else begin
            // Falling edge: advance to the next bit, or leave after the last one.
            sck <= 1'b0;
            if (bit_cnt == '0) begin
              state <= S_HOLD;
              cnt   <= CW'(CS_HOLD - 1);
            end else begin
              bit_cnt <= bit_cnt - 1'b1;
              shreg   <= shreg_sh;
              mosi    <= shreg_sh[WIDTH-1];
              cnt     <= CW'(CLKDIV - 1);
            end
          end
        end
        S_HOLD: begin
          if (cnt == '0) begin
            state  <= S_GAP;
            cnt    <= CW'(GAP - 1);
            ncs_xo <= 1'b1;
            mosi   <= 1'b0;
            done   <= 1'b1;
`ifdef XO_DAC_SPI_CTRL_SHADOW_EN
            last_word <= word_q;
`endif
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_GAP: begin
          if (cnt == '0) begin
            state    <= S_IDLE;
            wr_ready <= 1'b1;
            busy     <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state    <= S_IDLE;
          wr_ready <= 1'b1;
          busy     <= 1'b0;
          ncs_xo   <= 1'b1;
          sck      <= 1'b0;
          mosi     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xo_dac_spi_ctrl.sv
// Bench for xo_dac_spi_ctrl: per-cycle timing model derived from the frame timeline, SPI capture monitor.
module tb_xo_dac_spi_ctrl;

  localparam int W = 24, D = 4, S = 2, H = 2, G = 4;
  localparam int PER = 1 + S + 2*D*W + H + G;
  localparam int W2 = 16, D2 = 1;
  localparam int PER2 = 1 + S + 2*D2*W2 + H + G;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [W-1:0]  wr_data;
  logic          wr_valid;
  logic          wr_ready, busy, done, ncs_xo, sck, mosi;
  logic [W2-1:0] b_wr_data;
  logic          b_wr_valid;
  logic          b_wr_ready, b_busy, b_done, b_ncs_xo, b_sck, b_mosi;
`ifdef XO_DAC_SPI_CTRL_SHADOW_EN
  logic [W-1:0]  last_word;
  logic [W2-1:0] b_last_word;
`endif

  xo_dac_spi_ctrl #(.WIDTH(W), .CLKDIV(D), .CS_SETUP(S), .CS_HOLD(H), .GAP(G)) dut (
    .clk(clk), .rst_n(rst_n), .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .busy(busy), .done(done), .ncs_xo(ncs_xo), .sck(sck), .mosi(mosi)
`ifdef XO_DAC_SPI_CTRL_SHADOW_EN
    , .last_word(last_word)
`endif
  );

  xo_dac_spi_ctrl #(.WIDTH(W2), .CLKDIV(D2), .CS_SETUP(S), .CS_HOLD(H), .GAP(G)) dut_b (
    .clk(clk), .rst_n(rst_n), .wr_data(b_wr_data), .wr_valid(b_wr_valid), .wr_ready(b_wr_ready),
    .busy(b_busy), .done(b_done), .ncs_xo(b_ncs_xo), .sck(b_sck), .mosi(b_mosi)
`ifdef XO_DAC_SPI_CTRL_SHADOW_EN
    , .last_word(b_last_word)
`endif
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected {ncs, sck, mosi, ready, busy, done} k cycles after the acceptance edge (k >= 1).
  function automatic logic [5:0] model(input int k, input logic [31:0] w, input int wd, input int dv,
                                       output logic [5:0] msk);
    int sh_end;
    int j;
    sh_end = S + 2*dv*wd;
    msk = 6'h3f;
    if (k <= S) begin
      model = {2'b00, w[wd-1], 3'b010};
    end else if (k <= sh_end) begin
      j = k - S - 1;
      model = {1'b0, ((j % (2*dv)) >= dv), w[wd-1-j/(2*dv)], 3'b010};
    end else if (k <= sh_end + H) begin
      model = 6'b000010;
      msk = 6'b110111;
    end else if (k <= sh_end + H + G) begin
      model = {5'b10001, (k == sh_end + H + 1)};
    end else begin
      model = 6'b100100;
    end
  endfunction

  task automatic wait_ready();
    int t = 0;
    while (!wr_ready && t < 2*PER) begin
      step();
      t++;
    end
    chk("ready_wait", {31'd0, wr_ready}, 32'd1);
  endtask

  // Called at k=1 of a frame; checks every cycle through the return to IDLE (k=PER).
  task automatic frame_a(input logic [W-1:0] w, input string nm, input int poke_k);
    logic [5:0] e, m, a;
    logic [31:0] cap = 0;
    int nbits = 0, nlow = 0, ndone = 0;
    logic psck = 1'b0;
    for (int k = 1; k < PER; k++) begin
      e = model(k, {8'd0, w}, W, D, m);
      a = {ncs_xo, sck, mosi, wr_ready, busy, done};
      chk($sformatf("%s k=%0d", nm, k), {26'd0, a & m}, {26'd0, e & m});
      if (sck && !psck) begin
        cap = {cap[30:0], mosi};
        nbits++;
      end
      psck = sck;
      if (!ncs_xo) nlow++;
      if (done) ndone++;
      if (k == poke_k) begin
        wr_valid = 1'b1;
        wr_data  = 24'h123456;
      end else if (k == poke_k + 1) begin
        wr_valid = 1'b0;
      end
      step();
    end
    chk({nm, " idle_ready"}, {30'd0, wr_ready, busy}, 32'b10);
    chk({nm, " word"}, cap, {8'd0, w});
    chk({nm, " nbits"}, nbits, W);
    chk({nm, " ncs_low"}, nlow, 196);
    chk({nm, " ndone"}, ndone, 1);
  endtask

  typedef struct {
    logic [W-1:0] data;
    logic [W-1:0] exp_word;
    string        nm;
  } vec_t;

  initial begin
    vec_t tbl[4];
    logic [W-1:0] w;
    logic [5:0] e, m;
    logic [31:0] cap;
    int nbits, ndone;
    logic psck;

    tbl[0] = '{24'h00A5C3, 24'h00A5C3, "a5c3"};
    tbl[1] = '{24'hFFFFFF, 24'hFFFFFF, "ones"};
    tbl[2] = '{24'h000000, 24'h000000, "zeros"};
    tbl[3] = '{24'h800001, 24'h800001, "ends"};

    rst_n = 1'b0; wr_valid = 1'b0; wr_data = '0; b_wr_valid = 1'b0; b_wr_data = '0;
    repeat (3) step();
    chk("rst ncs/sck/mosi/rdy/busy/done", {26'd0, ncs_xo, sck, mosi, wr_ready, busy, done}, 32'b100100);
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step();
      chk($sformatf("idle c=%0d", i), {26'd0, ncs_xo, sck, mosi, wr_ready, busy, done}, 32'b100100);
    end
`ifdef XO_DAC_SPI_CTRL_SHADOW_EN
    chk("last_word rst", {8'd0, last_word}, 32'd0);
`endif

    // Table of single frames.
    for (int i = 0; i < 4; i++) begin
      wait_ready();
      wr_data = tbl[i].data; wr_valid = 1'b1;
      step();
      wr_valid = 1'b0;
      frame_a(tbl[i].exp_word, tbl[i].nm, -1);
`ifdef XO_DAC_SPI_CTRL_SHADOW_EN
      chk({tbl[i].nm, " last_word"}, {8'd0, last_word}, {8'd0, tbl[i].exp_word});
`endif
    end

    // Random words.
    for (int i = 0; i < 3; i++) begin
      w = W'($urandom);
      wait_ready();
      wr_data = w; wr_valid = 1'b1;
      step();
      wr_valid = 1'b0;
      frame_a(w, $sformatf("rand%0d", i), -1);
    end

    // Back-to-back with wr_valid held: the second frame must start right after the IDLE cycle.
    wait_ready();
    wr_data = 24'hFFFFFF; wr_valid = 1'b1;
    step();
    wr_data = 24'h000001;
    frame_a(24'hFFFFFF, "b2b0", -1);
    step();
    wr_valid = 1'b0;
    frame_a(24'h000001, "b2b1", -1);

    // Write while busy is ignored.
    wait_ready();
    wr_data = 24'h5A5A5A; wr_valid = 1'b1;
    step();
    wr_valid = 1'b0;
    frame_a(24'h5A5A5A, "busywr", 50);
    for (int i = 0; i < 20; i++) begin
      chk($sformatf("no_extra c=%0d", i), {30'd0, ncs_xo, busy}, 32'b10);
      step();
    end

    // Reset after bit 10 of the frame.
    w = 24'hABCDEF;
    wr_data = w; wr_valid = 1'b1;
    step();
    wr_valid = 1'b0;
    cap = 0; nbits = 0; psck = 1'b0;
    for (int k = 1; k <= S + 1 + 10*2*D; k++) begin
      if (sck && !psck) begin
        cap = {cap[30:0], mosi};
        nbits++;
      end
      psck = sck;
      if (k < S + 1 + 10*2*D) step();
    end
    rst_n = 1'b0;
    step();
    chk("midrst outs", {26'd0, ncs_xo, sck, mosi, wr_ready, busy, done}, 32'b100100);
    chk("midrst nbits", nbits, 10);
    chk("midrst bits", cap, {22'd0, w[23:14]});
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < PER; i++) begin
      step();
      if (done || !ncs_xo) ndone++;
    end
    chk("midrst no_done", ndone, 0);

    // Narrow, fast instance: WIDTH=16, CLKDIV=1.
    b_wr_data = 16'h8001; b_wr_valid = 1'b1;
    step();
    b_wr_valid = 1'b0;
    cap = 0; nbits = 0; psck = 1'b0;
    for (int k = 1; k < PER2; k++) begin
      e = model(k, 32'h8001, W2, D2, m);
      chk($sformatf("b k=%0d", k), {26'd0, {b_ncs_xo, b_sck, b_mosi, b_wr_ready, b_busy, b_done} & m},
          {26'd0, e & m});
      if (b_sck && !psck) begin
        cap = {cap[30:0], b_mosi};
        nbits++;
      end
      psck = b_sck;
      step();
    end
    chk("b word", cap, 32'h8001);
    chk("b nbits", nbits, W2);
    chk("b idle", {30'd0, b_wr_ready, b_busy}, 32'b10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
